// File: rtl/tensor_core_mma_seq.sv
// Sequential N x N matrix multiply-accumulate: snapshots A/B/C on start, then
// produces one output element per clock in row-major order.
module tensor_core_mma_seq #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                  clock_in,
  input  logic                                  reset_in,
  input  logic                                  start_calculation,
  input  logic                                  accumulate_mode,
  input  logic                                  saturate_enable,
  input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]   tensor_core_input1,
  input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]   tensor_core_input2,
  input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]   tensor_core_input3,
  output logic [N-1:0][N-1:0][DATA_WIDTH-1:0]   tensor_core_output,
  output logic                                  is_busy,
  output logic                                  is_done_with_calculation,
  output logic                                  result_valid
);
  localparam int DW   = DATA_WIDTH;
  localparam int PW   = 2 * DW;
  localparam int FW   = 2 * DW + $clog2(N) + 1;
  localparam int CW   = $clog2(N * N);
  localparam int RW   = $clog2(N);
  localparam int LAST = N * N - 1;

  typedef enum logic {IDLE, COMPUTE} state_t;
  typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  mat_t            a_q, b_q, c_q, d_q;
  logic            acc_q, sat_q, done_q, valid_q;

  logic [RW-1:0]        row, col;
  logic [N-1:0][PW-1:0] prod;
  logic [FW-1:0]        sum;
  logic [DW-1:0]        elem_d;

  assign row = RW'(cnt_q / CW'(N));
  assign col = RW'(cnt_q % CW'(N));

  // One dot product per cycle: N multipliers across the selected row/column.
  for (genvar i = 0; i < N; i++) begin : g_mul
    assign prod[i] = PW'(a_q[row][i]) * PW'(b_q[i][col]);
  end

  always_comb begin
    sum = acc_q ? FW'(c_q[row][col]) : '0;
    for (int i = 0; i < N; i++) sum = sum + FW'(prod[i]);
    elem_d = (sat_q && |sum[FW-1:DW]) ? '1 : sum[DW-1:0];
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      acc_q   <= 1'b0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_calculation) begin
            a_q     <= tensor_core_input1;
            b_q     <= tensor_core_input2;
            c_q     <= tensor_core_input3;
            acc_q   <= accumulate_mode;
            sat_q   <= saturate_enable;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          d_q[row][col] <= elem_d;
          if (cnt_q == CW'(LAST)) begin
            cnt_q   <= '0;
            valid_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tensor_core_output       = d_q;
  assign is_busy                  = (state_q == COMPUTE);
  assign is_done_with_calculation = done_q;
  assign result_valid             = valid_q;
endmodule

// File: tb/tb_tensor_core_mma_seq.sv
// Directed bench for tensor_core_mma_seq at N=4, DATA_WIDTH=8.
module tb_tensor_core_mma_seq;
  localparam int N = 4, DW = 8;
  typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;

  logic clk = 1'b0;
  logic rst, start, accm, sat;
  mat_t a, b, c, d;
  logic busy, done, valid;
  int   n_chk = 0, n_fail = 0;

  tensor_core_mma_seq #(.N(N), .DATA_WIDTH(DW)) dut (
    .clock_in(clk), .reset_in(rst), .start_calculation(start),
    .accumulate_mode(accm), .saturate_enable(sat),
    .tensor_core_input1(a), .tensor_core_input2(b), .tensor_core_input3(c),
    .tensor_core_output(d), .is_busy(busy),
    .is_done_with_calculation(done), .result_valid(valid));

  always #5 clk = ~clk;

  function automatic mat_t fill(input int v);
    mat_t m;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m[i][j] = DW'(v);
    return m;
  endfunction

  function automatic mat_t ident();
    mat_t m;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m[i][j] = (i == j) ? 8'd1 : 8'd0;
    return m;
  endfunction

  function automatic mat_t ramp(input int mul, input int off);
    mat_t m;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) m[i][j] = DW'(mul * (4 * i + j) + off);
    return m;
  endfunction

  // Drives one start pulse; returns just after the accepting edge E0.
  task automatic launch(input mat_t ai, input mat_t bi, input mat_t ci, input logic am, input logic sm);
    @(negedge clk);
    a = ai; b = bi; c = ci; accm = am; sat = sm; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Samples at the negedge after edge E0+j for j = 0..24.
  task automatic run_to_done(output int busy_n, output int done_j, output int pulses);
    busy_n = 0; done_j = -1; pulses = 0;
    for (int j = 0; j <= 24; j++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        pulses++;
        if (done_j < 0) done_j = j;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; accm = 1'b0; sat = 1'b0;
    a = '0; b = '0; c = '0;
    repeat (2) @(negedge clk);
    n_chk++; if (d !== '0)     begin n_fail++; $display("FAIL reset_d: got %h exp 0", d); end
    n_chk++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_chk++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", valid); end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    int bn, dj, pc;
    mat_t exp_m;
    exp_m = ramp(1, 0);
    launch(ident(), ramp(1, 0), fill(0), 1'b0, 1'b0);
    run_to_done(bn, dj, pc);
    n_chk++; if (bn !== 16)  begin n_fail++; $display("FAIL ident_busy_cycles: got %0d exp 16", bn); end
    n_chk++; if (dj !== 16)  begin n_fail++; $display("FAIL ident_done_edge: got %0d exp 16", dj); end
    n_chk++; if (pc !== 1)   begin n_fail++; $display("FAIL ident_done_pulses: got %0d exp 1", pc); end
    n_chk++; if (valid !== 1'b1) begin n_fail++; $display("FAIL ident_valid: got %b exp 1", valid); end
    n_chk++; if (d !== exp_m) begin n_fail++; $display("FAIL ident_d: got %h exp %h", d, exp_m); end
  endtask

  task automatic test_accumulate();
    int bn, dj, pc;
    mat_t exp_m;
    exp_m = fill(8);
    launch(ident(), fill(3), fill(5), 1'b1, 1'b0);
    run_to_done(bn, dj, pc);
    n_chk++; if (dj !== 16)   begin n_fail++; $display("FAIL acc_done_edge: got %0d exp 16", dj); end
    n_chk++; if (d !== exp_m) begin n_fail++; $display("FAIL acc_d: got %h exp %h", d, exp_m); end
  endtask

  task automatic test_saturate();
    int bn, dj, pc;
    mat_t exp_m;
    // 4*16*16 = 1024: low byte is 0
    exp_m = fill(0);
    launch(fill(16), fill(16), fill(0), 1'b0, 1'b0);
    run_to_done(bn, dj, pc);
    n_chk++; if (d !== exp_m) begin n_fail++; $display("FAIL wrap_1024: got %h exp %h", d, exp_m); end
    // 250 + 6 = 256 wraps to 0 without clamping
    launch(ident(), fill(250), fill(6), 1'b1, 1'b0);
    run_to_done(bn, dj, pc);
    n_chk++; if (d !== exp_m) begin n_fail++; $display("FAIL wrap_256: got %h exp %h", d, exp_m); end
    // in-range values pass through untouched with clamping on
    exp_m = ramp(1, 0);
    launch(ident(), ramp(1, 0), fill(0), 1'b0, 1'b1);
    run_to_done(bn, dj, pc);
    n_chk++; if (d !== exp_m) begin n_fail++; $display("FAIL sat_inrange: got %h exp %h", d, exp_m); end
    exp_m = fill(255);
    launch(fill(16), fill(16), fill(0), 1'b0, 1'b1);
    run_to_done(bn, dj, pc);
    n_chk++; if (d !== exp_m) begin n_fail++; $display("FAIL sat_1024: got %h exp %h", d, exp_m); end
  endtask

  // Previous result is all 255; mid-run changes and a restart pulse must be ignored.
  task automatic test_ignore_restart();
    int dj, pc;
    mat_t exp_m, prior;
    exp_m = ramp(2, 1);
    prior = fill(255);
    dj = -1; pc = 0;
    launch(ident(), ramp(2, 1), fill(9), 1'b0, 1'b0);
    for (int j = 0; j <= 24; j++) begin
      @(negedge clk);
      if (j == 4) begin
        n_chk++; if (d[0] !== exp_m[0]) begin n_fail++; $display("FAIL partial_row0: got %h exp %h", d[0], exp_m[0]); end
        n_chk++; if (d[3:1] !== prior[3:1]) begin n_fail++; $display("FAIL retain_rows: got %h exp %h", d[3:1], prior[3:1]); end
        n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL valid_midop: got %b exp 0", valid); end
        a = fill(2); b = fill(7); c = fill(1); accm = 1'b1; start = 1'b1;
      end
      if (j == 5) start = 1'b0;
      if (done) begin pc++; if (dj < 0) dj = j; end
    end
    n_chk++; if (pc !== 1)    begin n_fail++; $display("FAIL ignore_pulses: got %0d exp 1", pc); end
    n_chk++; if (dj !== 16)   begin n_fail++; $display("FAIL ignore_done_edge: got %0d exp 16", dj); end
    n_chk++; if (d !== exp_m) begin n_fail++; $display("FAIL ignore_d: got %h exp %h", d, exp_m); end
  endtask

  task automatic test_reset_midop();
    int bn, dj, pc;
    mat_t exp_m;
    launch(ident(), fill(4), fill(0), 1'b0, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++; if (d !== '0)       begin n_fail++; $display("FAIL midrst_d: got %h exp 0", d); end
    n_chk++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL midrst_busy: got %b exp 0", busy); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b exp 0", valid); end
    @(negedge clk);
    rst = 1'b0;
    pc = 0;
    repeat (20) begin @(negedge clk); if (done) pc++; end
    n_chk++; if (pc !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d exp 0", pc); end
    exp_m = ramp(1, 0);
    launch(ident(), ramp(1, 0), fill(0), 1'b0, 1'b0);
    run_to_done(bn, dj, pc);
    n_chk++; if (bn !== 16)   begin n_fail++; $display("FAIL postrst_busy: got %0d exp 16", bn); end
    n_chk++; if (dj !== 16)   begin n_fail++; $display("FAIL postrst_done_edge: got %0d exp 16", dj); end
    n_chk++; if (d !== exp_m) begin n_fail++; $display("FAIL postrst_d: got %h exp %h", d, exp_m); end
  endtask

  // Start held high: op2 is accepted on the edge that samples done high (E0+17).
  task automatic test_back_to_back();
    int d1, d2, pc;
    mat_t exp1, exp2;
    exp1 = ramp(1, 0); exp2 = fill(6);
    d1 = -1; d2 = -1; pc = 0;
    @(negedge clk);
    a = ident(); b = ramp(1, 0); c = fill(0); accm = 1'b0; sat = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 45; j++) begin
      @(negedge clk);
      if (j == 2) b = fill(6);
      if (j == 16) begin
        n_chk++; if (d !== exp1) begin n_fail++; $display("FAIL b2b_first_d: got %h exp %h", d, exp1); end
      end
      if (j == 17) start = 1'b0;
      if (j == 20) begin
        n_chk++; if (busy !== 1'b1 || valid !== 1'b0)
          begin n_fail++; $display("FAIL b2b_second_running: got busy=%b valid=%b exp busy=1 valid=0", busy, valid); end
      end
      if (done) begin
        pc++;
        if (d1 < 0) d1 = j; else if (d2 < 0) d2 = j;
      end
    end
    n_chk++; if (pc !== 2)   begin n_fail++; $display("FAIL b2b_pulses: got %0d exp 2", pc); end
    n_chk++; if (d1 !== 16)  begin n_fail++; $display("FAIL b2b_first_done: got %0d exp 16", d1); end
    n_chk++; if (d2 !== 33)  begin n_fail++; $display("FAIL b2b_second_done: got %0d exp 33", d2); end
    n_chk++; if (d !== exp2) begin n_fail++; $display("FAIL b2b_second_d: got %h exp %h", d, exp2); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_accumulate();
    test_saturate();
    test_ignore_restart();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
